keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad: drives one column low at a time and samples the four row inputs.
- Debounces all 16 keys and reports each new press as a one-cycle key-code event.
- Input-side counterpart of the multiplexed display driver: column strobing mirrors digit strobing.
- Feeds the game logic with key events and a debounced key map.

---
 rtl/keypad_scanner.sv | 98 +++++++++
 tb/tb_keypad_scanner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column at a time, debounces all 16 keys
// and reports each new press as a one-cycle key-code pulse, lowest code first.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  KEY_ROW,
    output logic [3:0]  KEY_COL,
    output logic [15:0] key_map,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE_SCANS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [15:0]      map_q, map_d;
    logic [15:0]      pend_q, pend_d;
    logic [3:0]       cnt_q [16];
    logic [3:0]       cnt_d [16];
    logic             valid_q, valid_d;
    logic [3:0]       code_q, code_d;

    logic             sample;
    logic [3:0]       raw;
    logic [3:0]       k;
    logic [15:0]      grant;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sample  = (div_q == DIV_LAST);
        div_d   = sample ? '0 : div_q + 1'b1;
        col_d   = sample ? col_q + 2'd1 : col_q;
        raw     = ~KEY_ROW;
        k       = '0;
        map_d   = map_q;
        cnt_d   = cnt_q;
        valid_d = |pend_q;
        code_d  = code_q;

        // Only the four keys of the column being driven see a sample this cycle.
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                k = {col_q, r[1:0]};
                if (raw[r] == map_q[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] == DB_LAST) begin
                    map_d[k] = ~map_q[k];
                    cnt_d[k] = '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + 4'd1;
                end
            end
        end

        // Two's-complement trick isolates the lowest pending bit.
        grant = pend_q & (~pend_q + 16'd1);
        for (int i = 15; i >= 0; i--) begin
            if (pend_q[i]) code_d = 4'(i);
        end

        // A new press on the bit being granted this cycle stays pending.
        pend_d = (pend_q & ~grant) | (map_d & ~map_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            col_q   <= '0;
            map_q   <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            // NOTE: the counter array is cleared on reset so a key held through reset must debounce again from zero.
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            div_q   <= div_d;
            col_q   <= col_d;
            map_q   <= map_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign KEY_COL   = ~(4'b0001 << col_q);
    assign key_map   = map_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a matrix of held keys drives the row lines,
// a key-level behavioural model predicts every output, plus hand-computed directed checks.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  KEY_ROW;
    logic [3:0]  KEY_COL;
    logic [15:0] key_map;
    logic        key_valid;
    logic [3:0]  key_code;

    int tests = 0;
    int fails = 0;

    bit held [16];
    int ev   [16];

    // behavioural model state
    int m_div, m_col, m_code;
    bit m_map [16];
    int m_cnt [16];
    bit m_pend [16];
    bit m_valid;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .KEY_ROW   (KEY_ROW),
        .KEY_COL   (KEY_COL),
        .key_map   (key_map),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    // Physical matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        KEY_ROW = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!KEY_COL[c] && held[c*4+r]) KEY_ROW[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Key-level model: time in cycles, column from time, one report per cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_div = 0; m_col = 0; m_valid = 0; m_code = 0;
            for (int i = 0; i < 16; i++) begin
                m_map[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
            end
        end else begin
            bit found;
            found = 0;
            for (int i = 0; i < 16; i++) begin
                if (!found && m_pend[i]) begin
                    found = 1; m_code = i; m_pend[i] = 0;
                end
            end
            m_valid = found;
            if (m_div == SD - 1) begin
                for (int r = 0; r < 4; r++) begin
                    int kk;
                    kk = m_col * 4 + r;
                    if (held[kk] == m_map[kk]) m_cnt[kk] = 0;
                    else if (m_cnt[kk] == DB - 1) begin
                        m_map[kk] = !m_map[kk];
                        m_cnt[kk] = 0;
                        if (m_map[kk]) m_pend[kk] = 1;
                    end else m_cnt[kk]++;
                end
                m_col = (m_col + 1) % 4;
            end
            m_div = (m_div + 1) % SD;
        end
    end

    // Compare every cycle, clear of the clock edge.
    always @(posedge clk) begin
        logic [15:0] exp_map;
        #2;
        for (int i = 0; i < 16; i++) exp_map[i] = m_map[i];
        check("key_col",   {28'd0, KEY_COL}, {28'd0, ~(4'b0001 << m_col)});
        check("key_map",   {16'd0, key_map}, {16'd0, exp_map});
        check("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
        check("key_code",  {28'd0, key_code}, m_code);
        if (key_valid) ev[key_code]++;
    end

    task automatic clear_ev();
        for (int i = 0; i < 16; i++) ev[i] = 0;
    endtask

    // Returns at the negedge inside the sample cycle of column col.
    task automatic at_sample(input int col);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_div == SD - 1 && m_col == col) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("sample_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 16; i++) held[i] = 0;
        clear_ev();
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, KEY_COL}, 32'he);
        check("rst_map", {16'd0, key_map}, 0);
        check("rst_valid", {31'd0, key_valid}, 0);
        rst = 1'b1;

        // Column strobe sequence, 4 cycles per column.
        repeat (4) @(negedge clk); check("step1", {28'd0, KEY_COL}, 32'hd);
        repeat (4) @(negedge clk); check("step2", {28'd0, KEY_COL}, 32'hb);
        repeat (4) @(negedge clk); check("step3", {28'd0, KEY_COL}, 32'h7);
        repeat (4) @(negedge clk); check("step4", {28'd0, KEY_COL}, 32'he);

        // Key 9: press accepted on 2nd sample, map then pulse.
        clear_ev();
        at_sample(2); held[9] = 1;
        at_sample(2);
        check("k9_pre", {31'd0, key_map[9]}, 0);
        @(negedge clk);
        check("k9_map", {31'd0, key_map[9]}, 1);
        check("k9_nopulse", {31'd0, key_valid}, 0);
        @(negedge clk);
        check("k9_valid", {31'd0, key_valid}, 1);
        check("k9_code", {28'd0, key_code}, 9);
        repeat (40) @(negedge clk);
        check("k9_once", ev[9], 1);

        // Release over 2 samples: map clears, no event.
        at_sample(2); held[9] = 0;
        at_sample(2);
        repeat (2) @(negedge clk);
        check("k9_release_map", {31'd0, key_map[9]}, 0);
        check("k9_release_noev", ev[9], 1);

        // Bounce: alternating samples never reach 2 in a row.
        clear_ev();
        at_sample(2); held[9] = 1;
        at_sample(2); held[9] = 0;
        at_sample(2); held[9] = 1;
        at_sample(2); held[9] = 0;
        repeat (3) @(negedge clk);
        check("bounce_map", {31'd0, key_map[9]}, 0);
        check("bounce_noev", ev[9], 0);
        at_sample(2); held[9] = 1;
        at_sample(2);
        repeat (3) @(negedge clk);
        check("repress_map", {31'd0, key_map[9]}, 1);
        check("repress_ev", ev[9], 1);
        held[9] = 0;
        at_sample(2); at_sample(2); at_sample(2);

        // Keys 4 and 7 in one sample: codes 4 then 7 on consecutive cycles.
        at_sample(1); held[4] = 1; held[7] = 1;
        at_sample(1);
        @(negedge clk);
        check("k47_map", {28'd0, key_map[7:4]}, 32'h9);
        @(negedge clk);
        check("k4_valid", {31'd0, key_valid}, 1);
        check("k4_code", {28'd0, key_code}, 4);
        @(negedge clk);
        check("k7_valid", {31'd0, key_valid}, 1);
        check("k7_code", {28'd0, key_code}, 7);
        @(negedge clk);
        check("k47_done", {31'd0, key_valid}, 0);
        check("k47_hold_code", {28'd0, key_code}, 7);
        held[4] = 0; held[7] = 0;
        at_sample(1); at_sample(1); at_sample(1);

        // Reset mid-dwell with key 5 debounced and still held.
        held[5] = 1;
        at_sample(1); at_sample(1); at_sample(1);
        check("k5_map", {31'd0, key_map[5]}, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_col", {28'd0, KEY_COL}, 32'he);
        check("mid_rst_map", {16'd0, key_map}, 0);
        check("mid_rst_valid", {31'd0, key_valid}, 0);
        check("mid_rst_code", {28'd0, key_code}, 0);
        @(negedge clk);
        rst = 1'b1;
        clear_ev();
        at_sample(1); at_sample(1);
        repeat (3) @(negedge clk);
        check("k5_after_rst_map", {31'd0, key_map[5]}, 1);
        check("k5_after_rst_ev", ev[5], 1);
        held[5] = 0;

        // Random key activity with occasional resets, checked by the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) held[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
